// File: rtl/z3_dma_initiator.sv
// z3_dma_initiator
// Zorro III bus-master cycle sequencer. Once the arbiter has granted the bus
// (bmaster) and the SCSI controller raises a local master cycle (req), this
// block drives the initiator half of the Zorro III handshake (FCS_n, DS_n,
// DOE), samples the target response (DTACK_n / BERR_n), and hands the local
// termination (sterm_n or lberr_n) back to the SCSI chip. Every cycle is
// bounded by a watchdog, and a bus error is retried up to MAX_RETRY times.
//
// Handshake semantics: a local cycle is requested by holding req high. The
// block answers with exactly one termination per request: a single-cycle
// sterm_n low pulse on success, or lberr_n held low until req is dropped.
// After a successful termination the block waits for req to drop and for
// DTACK to be released before it becomes idle, so a new cycle never starts
// while the previous target is still acknowledging.
//
// All Zorro outputs are plain two-state signals decoded from the state
// register; the board top level tri-states them with bmaster. Because they
// are decoded from an asynchronously reset register, asserting RESET_n
// negates them immediately.

module z3_dma_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       bmaster,
  input  logic       req,
  input  logic       read,
  input  logic [1:0] siz,
  input  logic [1:0] addr_lo,
  input  logic       dtack_n,
  input  logic       berr_n,
  output logic       fcs_n,
  output logic [3:0] ds_n,
  output logic       doe,
  output logic       sterm_n,
  output logic       lberr_n,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT    = 3'd3,
    S_TERM    = 3'd4,
    S_RELEASE = 3'd5,
    S_RETRY   = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // Last watchdog value before the cycle is abandoned, and the retry ceiling.
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

  // Synchronizer stages (active-high versions of the bus responses).
  logic dtack_meta;
  logic dtack_s;
  logic berr_meta;
  logic berr_s;

  // Sequencer state and per-cycle context.
  state_t     state_q;
  state_t     state_d;
  logic [7:0] wd_q;
  logic [7:0] wd_d;
  logic [1:0] retry_q;
  logic [1:0] retry_d;
  logic [3:0] lanes_q;
  logic [3:0] lanes_d;
  logic       rd_q;
  logic       rd_d;

  // Lane decode of the current request (active-high byte enables).
  logic [2:0] n_bytes;
  logic [2:0] span_end;
  logic [3:0] wr_mask;
  logic [3:0] lane_mask_new;

  // Strobe-phase decode shared by several outputs.
  logic strobing;
  logic addressing;

  // Two-flop synchronizers for the asynchronous Zorro responses.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      dtack_meta <= 1'b0;
      dtack_s    <= 1'b0;
      berr_meta  <= 1'b0;
      berr_s     <= 1'b0;
    end else begin
      dtack_meta <= ~dtack_n;
      dtack_s    <= dtack_meta;
      berr_meta  <= ~berr_n;
      berr_s     <= berr_meta;
    end
  end

  // Byte-lane decode: writes enable bytes addr_lo .. addr_lo+n-1, clipped at
  // byte 3 (the long-word boundary); reads always enable all four lanes.
  // Byte b of the long word is carried on lane 3-b.
  always_comb begin
    n_bytes  = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
    span_end = {1'b0, addr_lo} + n_bytes - 3'd1;
    wr_mask  = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      wr_mask[3-b] = (3'(b) >= {1'b0, addr_lo}) && (3'(b) <= span_end);
    end
    lane_mask_new = read ? 4'b1111 : wr_mask;
  end

  // Sequencer state register and cycle context.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      wd_q    <= 8'd0;
      retry_q <= 2'd0;
      lanes_q <= 4'b0000;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      retry_q <= retry_d;
      lanes_q <= lanes_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state logic. Loss of bus grant beats every other event while we
  // own the bus; inside WAIT a bus error beats DTACK, which beats timeout.
  // Direction and lanes are captured on each entry to ADDR, and the
  // watchdog restarts there.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    retry_d = retry_q;
    lanes_d = lanes_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        retry_d = 2'd0;
        if (req && bmaster) begin
          state_d = S_ADDR;
          wd_d    = 8'd0;
          lanes_d = lane_mask_new;
          rd_d    = read;
        end
      end
      S_ADDR: begin
        if (!bmaster) state_d = S_ERROR;
        else          state_d = S_STROBE;
      end
      S_STROBE: begin
        if (!bmaster) state_d = S_ERROR;
        else          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!bmaster)               state_d = S_ERROR;
        else if (berr_s)            state_d = S_RETRY;
        else if (dtack_s)           state_d = S_TERM;
        else if (wd_q == WD_LAST)   state_d = S_ERROR;
        else                        wd_d    = wd_q + 8'd1;
      end
      S_TERM: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!dtack_s && !req) state_d = S_IDLE;
      end
      S_RETRY: begin
        if (!bmaster) begin
          state_d = S_ERROR;
        end else if (retry_q == RETRY_MAX) begin
          state_d = S_ERROR;
        end else if (!berr_s && !dtack_s) begin
          retry_d = retry_q + 2'd1;
          state_d = S_ADDR;
          wd_d    = 8'd0;
          lanes_d = lane_mask_new;
          rd_d    = read;
        end
      end
      S_ERROR: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state. FCS and DS share the same
  // negation edge because both drop on leaving WAIT.
  always_comb begin
    addressing = (state_q == S_ADDR) || strobing;
    strobing   = (state_q == S_STROBE) || (state_q == S_WAIT);
    fcs_n      = ~addressing;
    ds_n       = strobing ? ~lanes_q : 4'b1111;
    doe        = strobing && !rd_q;
    sterm_n    = (state_q != S_TERM);
    lberr_n    = (state_q != S_ERROR);
    busy       = (state_q != S_IDLE);
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_z3_dma_initiator.sv
// Testbench for z3_dma_initiator. A small target responder is folded into a
// cycle-stepped transaction task; expected lanes, attempt counts and the
// final termination come from a transaction-level model of the bus rules.

module tb_z3_dma_initiator;

  localparam int TO = 16;
  localparam int MR = 3;

  logic       CLK;
  logic       RESET_n;
  logic       bmaster;
  logic       req;
  logic       rd;
  logic [1:0] siz;
  logic [1:0] addr_lo;
  logic       dtack_n;
  logic       berr_n;
  logic       fcs_n;
  logic [3:0] ds_n;
  logic       doe;
  logic       sterm_n;
  logic       lberr_n;
  logic       busy;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  z3_dma_initiator #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .bmaster(bmaster),
    .req(req),
    .read(rd),
    .siz(siz),
    .addr_lo(addr_lo),
    .dtack_n(dtack_n),
    .berr_n(berr_n),
    .fcs_n(fcs_n),
    .ds_n(ds_n),
    .doe(doe),
    .sterm_n(sterm_n),
    .lberr_n(lberr_n),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // Clock and reset: 25 MHz
  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: which data strobes (active-low) a transfer should drive.
  function automatic logic [3:0] model_ds(input logic r, input logic [1:0] s, input logic [1:0] a);
    logic [3:0] res;
    int n;
    int first;
    res = 4'b1111;
    if (r) return 4'b0000;
    case (s)
      2'b00: n = 4;
      2'b01: n = 1;
      2'b10: n = 2;
      default: n = 3;
    endcase
    first = int'(a);
    for (int byte_i = 0; byte_i < 4; byte_i++)
      if (byte_i >= first && byte_i < first + n) res[3 - byte_i] = 1'b0;
    return res;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One local master cycle. nberr = number of attempts the target answers
  // with BERR before it answers with DTACK; dly = strobe cycles before the
  // target responds; no_resp = target never responds.
  task automatic run_txn(input logic r, input logic [1:0] s, input logic [1:0] a,
                         input int nberr, input int dly, input bit no_resp);
    int exp_attempts;
    bit exp_ok;
    int fcs_falls, sterm_cnt, strobe_samples, attempt_start, resp_sample;
    int attempts_done, lberr_hold;
    bit responding, prev_fcs, lberr_seen, done, sterm_seen;
    exp_q.push_back(model_ds(r, s, a));
    if (no_resp) begin
      exp_ok = 1'b0;
      exp_attempts = 1;
    end else if (nberr <= MR) begin
      exp_ok = 1'b1;
      exp_attempts = nberr + 1;
    end else begin
      exp_ok = 1'b0;
      exp_attempts = MR + 1;
    end
    fcs_falls = 0; sterm_cnt = 0; strobe_samples = 0; attempt_start = 0;
    resp_sample = 0; attempts_done = 0; lberr_hold = 0;
    responding = 0; prev_fcs = 1; lberr_seen = 0; done = 0; sterm_seen = 0;
    rd = r; siz = s; addr_lo = a; req = 1'b1;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      tick();
      if (cyc == 1) check("req_to_fcs", fcs_n, 1'b0);
      if (prev_fcs && !fcs_n) begin
        fcs_falls++;
        strobe_samples = 0;
        attempt_start = cyc;
      end
      if (ds_n !== 4'b1111) begin
        strobe_samples++;
        if (strobe_samples == 1) check("fcs_to_ds", cyc - attempt_start, 1);
        check("ds_lanes", ds_n, exp_q[0]);
        check("doe", doe, !r);
        check("fcs_with_ds", fcs_n, 1'b0);
        if (!responding && !no_resp && strobe_samples == dly) begin
          responding = 1;
          resp_sample = cyc;
          if (attempts_done < nberr) berr_n = 1'b0;
          else dtack_n = 1'b0;
        end
      end
      if (fcs_n && responding) begin
        check("ds_neg_with_fcs", ds_n, 4'b1111);
        berr_n = 1'b1;
        dtack_n = 1'b1;
        responding = 0;
        attempts_done++;
      end
      if (!sterm_n) begin
        sterm_cnt++;
        if (!sterm_seen) check("dtack_to_sterm", cyc - resp_sample, 3);
        sterm_seen = 1;
        req = 1'b0;
      end
      if (!lberr_n && !lberr_seen) begin
        lberr_seen = 1;
        check("err_fcs_neg", fcs_n, 1'b1);
        check("err_ds_neg", ds_n, 4'b1111);
        if (no_resp) check("timeout_len", strobe_samples, TO + 1);
      end
      if (lberr_seen && req) begin
        lberr_hold++;
        check("lberr_held", lberr_n, 1'b0);
        if (lberr_hold == 3) req = 1'b0;
      end
      if (!req && !busy) done = 1;
      prev_fcs = fcs_n;
    end
    check("txn_done", done, 1'b1);
    check("attempts", fcs_falls, exp_attempts);
    check("sterm_pulses", sterm_cnt, exp_ok ? 1 : 0);
    check("lberr_seen", lberr_seen, !exp_ok);
    check("idle_lberr", lberr_n, 1'b1);
    void'(exp_q.pop_front());
    req = 1'b0; dtack_n = 1'b1; berr_n = 1'b1;
    tick();
  endtask

  initial begin
    RESET_n = 1'b0; bmaster = 1'b1; req = 1'b0; rd = 1'b0; siz = 2'b00;
    addr_lo = 2'b00; dtack_n = 1'b1; berr_n = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_fcs", fcs_n, 1'b1);
    check("rst_ds", ds_n, 4'b1111);
    check("rst_doe", doe, 1'b0);
    check("rst_sterm", sterm_n, 1'b1);
    check("rst_lberr", lberr_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    @(negedge CLK);
    RESET_n = 1'b1;
    tick();

    // Directed transfers
    run_txn(1'b0, 2'b00, 2'd0, 0, 4, 0);   // long write
    run_txn(1'b0, 2'b01, 2'd2, 0, 2, 0);   // byte write, ds 1101
    run_txn(1'b0, 2'b11, 2'd1, 0, 3, 0);   // 3-byte write, ds 1000
    run_txn(1'b0, 2'b10, 2'd3, 0, 1, 0);   // word write truncated, ds 1110
    run_txn(1'b1, 2'b01, 2'd2, 0, 2, 0);   // byte read, all lanes
    run_txn(1'b0, 2'b00, 2'd0, 2, 2, 0);   // two BERRs then DTACK
    run_txn(1'b1, 2'b00, 2'd0, 5, 1, 0);   // BERR every attempt
    run_txn(1'b0, 2'b10, 2'd0, 0, 1, 1);   // no response: watchdog

    // Randomized transfers
    for (int i = 0; i < 12; i++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom_range(0, 4),
              $urandom_range(1, 8), 0);
    end

    // Grant lost while waiting for DTACK
    rd = 1'b0; siz = 2'b00; addr_lo = 2'd0; req = 1'b1;
    repeat (4) tick();
    check("bm_pre_ds", ds_n, 4'b0000);
    bmaster = 1'b0;
    tick();
    check("bm_lberr", lberr_n, 1'b0);
    check("bm_fcs", fcs_n, 1'b1);
    check("bm_ds", ds_n, 4'b1111);
    req = 1'b0; bmaster = 1'b1;
    tick();
    check("bm_idle", busy, 1'b0);

    // Reset pulsed during STROBE
    req = 1'b1;
    tick();
    tick();
    check("rst_mid_ds", ds_n, 4'b0000);
    #2 RESET_n = 1'b0;
    #1;
    check("rstm_fcs", fcs_n, 1'b1);
    check("rstm_ds", ds_n, 4'b1111);
    check("rstm_doe", doe, 1'b0);
    check("rstm_busy", busy, 1'b0);
    req = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    tick();
    check("rstm_after", busy, 1'b0);

    // A normal cycle still works after the mid-cycle reset
    run_txn(1'b0, 2'b01, 2'd3, 0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
